// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared types and op-decode helpers for muldiv_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative radix-2 RV32M/RV64M multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  op_e                 op_q, op_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;

  op_e                 op_in;
  logic                sign_a, sign_b, b_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, special_res;
  logic                mul_mode;
  logic [XLEN:0]       add_x, add_y, sum;
  logic [2*XLEN-1:0]   acc_step, prod;
  logic [XLEN-1:0]     quot, rem, final_res;

  // Operand decode at accept time
  always_comb begin
    op_in   = op_e'(op);
    sign_a  = is_signed_a(op_in) & a[XLEN-1];
    sign_b  = is_signed_b(op_in) & b[XLEN-1];
    mag_a   = sign_a ? -a : a;
    mag_b   = sign_b ? -b : b;
    b_zero  = (b == '0);
    div_ovf = (op_in == OP_DIV || op_in == OP_REM) &&
              (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    if (is_rem(op_in)) special_res = b_zero ? a : '0;
    else               special_res = b_zero ? '1 : a;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_mode = !is_div(op_q);
    add_x    = mul_mode ? {1'b0, acc_q[2*XLEN-1:XLEN]} : acc_q[2*XLEN-1:XLEN-1];
    add_y    = mul_mode ? {1'b0, opnd_q} : ~{1'b0, opnd_q};
    sum      = add_x + add_y + {{XLEN{1'b0}}, ~mul_mode};
    if (mul_mode) begin
      acc_step = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end else if (!sum[XLEN]) begin
      acc_step = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign fixups applied to the value produced by the last iteration
  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quot = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quot;
      default:                      final_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    zero_d    = zero_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d = op_in;
          if (is_div(op_in) && (b_zero || div_ovf)) begin
            state_d  = FIN;
            result_d = special_res;
            zero_d   = (special_res == '0);
          end else begin
            state_d   = CALC;
            cnt_d     = CNT_W'(XLEN);
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            // Divide: dividend in the low half; multiply: multiplier in the low half
            acc_d     = {{XLEN{1'b0}}, (is_div(op_in) ? mag_a : mag_b)};
            opnd_d    = is_div(op_in) ? mag_b : mag_a;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = FIN;
          result_d = final_res;
          zero_d   = (final_res == '0);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN) && !flush;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : self-checking bench for muldiv_unit (XLEN=32)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              flush = 1'b0;
  logic [2:0]        op = 3'd0;
  logic [XLEN-1:0]   a = '0;
  logic [XLEN-1:0]   b = '0;
  logic              busy, done, zero;
  logic [XLEN-1:0]   result;

  int                checks = 0;
  int                errors = 0;
  logic [XLEN-1:0]   last_exp = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics using wide integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sp;
    logic [63:0] p;
    logic        ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin sp = sx * sy; p = sp; return p[63:32]; end
      3'd2: begin sp = sx * longint'({32'b0, y}); p = sp; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        sp = sx / sy; p = sp; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        sp = sx % sy; p = sp; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Issue one op from an IDLE cycle and check result, zero, latency, busy span.
  // Returns in the first IDLE cycle after done, so calls chain back-to-back.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input string name);
    int cyc, busy_cnt, exp_lat;
    bit seen;
    exp_lat = is_special(o, x, y) ? 1 : XLEN + 1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1; busy_cnt = 0; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      checks++;
      if (result !== exp) begin
        errors++; $display("FAIL %s result: got %h expected %h", name, result, exp);
      end
      checks++;
      if (zero !== (exp == 0)) begin
        errors++; $display("FAIL %s zero: got %b expected %b", name, zero, (exp == 0));
      end
      checks++;
      if (cyc !== exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
      end
      checks++;
      if (busy_cnt !== exp_lat) begin
        errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_lat);
      end
      last_exp = exp;
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after done: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h zero=%b expected 0 0 0 1", busy, done, result, zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: busy=%b result=%h zero=%b expected 0 0 1", busy, result, zero);
    end
  endtask

  task automatic test_directed();
    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    do_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
    do_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    do_op(3'd5, 32'd100,        32'd7,         32'd14,        "divu_100_7");
    do_op(3'd7, 32'd100,        32'd7,         32'd2,         "remu_100_7");
    do_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by_0");
    do_op(3'd7, 32'd5,          32'd0,         32'd5,         "remu_by_0");
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
  endtask

  task automatic test_back_to_back();
    do_op(3'd5, 32'd9,         32'd3, 32'd3,          "b2b_divu");
    do_op(3'd3, 32'h8000_0000, 32'd4, 32'h0000_0002,  "b2b_mulhu");
  endtask

  task automatic test_busy_start();
    int cyc;
    bit seen;
    op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; seen = 0;
    while (cyc < 40 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    checks++;
    if (!seen || result !== 32'd14) begin
      errors++; $display("FAIL busy_start result: seen=%b got %h expected %h", seen, result, 32'd14);
    end
    // start during FIN must also be ignored
    op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_in_fin: busy=%b expected 0", busy);
    end
    last_exp = 32'd14;
  endtask

  task automatic test_flush();
    bit seen;
    // start together with flush is not accepted
    op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_with_start: busy=%b expected 0", busy);
    end
    op = 3'd0; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_pre busy: got %b expected 1", busy);
    end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_calc busy: got %b expected 0", busy);
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || result !== last_exp || zero !== (last_exp == 0)) begin
      errors++;
      $display("FAIL flush_calc hold: done_seen=%b result=%h zero=%b expected 0 %h %b", seen, result, zero, last_exp, (last_exp == 0));
    end
    // flush in FIN suppresses done but result is already written
    op = 3'd4; a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL flush_fin: done=%b result=%h expected 0 ffffffff", done, result);
    end
    @(posedge clk); #1; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_fin busy: got %b expected 0", busy);
    end
    last_exp = 32'hFFFF_FFFF;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 50; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: x = 32'd0;
        1: x = 32'h8000_0000;
        2: x = 32'hFFFF_FFFF;
        3: x = 32'($urandom_range(0, 20));
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      do_op(o, x, y, ref_res(o, x, y), $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h zero=%b expected 0 0 0 1", busy, done, result, zero);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid after: done_seen=%b busy=%b expected 0 0", seen, busy);
    end
    last_exp = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_start();
    test_flush();
    test_random();
    test_reset_mid();
    do_op(3'd5, 32'd100, 32'd10, 32'd10, "post_reset_divu");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
